hycontrol_packet_buffer: RTL and testbench

// Parametrised multi-slot packet buffer for HY control packets. It replaces
// the fixed 32x8 single-buffer RAM. Write side: framed byte stream with

---
 rtl/hycontrol_packet_buffer.sv | 169 ++++++++++++++++
 tb/tb_hycontrol_packet_buffer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hycontrol_packet_buffer.sv
// Multi-slot HY control packet buffer: framed words in, committed packets replayed in arrival order with length.
// First word valid two cycles after commit; s_ready low while every slot holds an unread packet; outputs hold under m_ready low.
module hycontrol_packet_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int SLOT_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  s_abort,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [ADDR_WIDTH:0]   m_len,
  input  logic                  m_ready,
  output logic [SLOT_BITS:0]    pkt_count,
  output logic                  overflow_err
);

  localparam int SLOTS = 1 << SLOT_BITS;
  localparam int WORDS = 1 << (SLOT_BITS + ADDR_WIDTH);

  localparam logic W_ACCEPT = 1'b0;
  localparam logic W_DROP   = 1'b1;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_FETCH = 2'd1;
  localparam logic [1:0] R_SEND  = 2'd2;

  localparam logic [SLOT_BITS:0]    FULL_CNT = {1'b1, {SLOT_BITS{1'b0}}};
  localparam logic [SLOT_BITS:0]    PKT_ONE  = 1;
  localparam logic [SLOT_BITS-1:0]  SLOT_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;

  logic [DATA_WIDTH-1:0]             mem [WORDS];
  logic [SLOTS-1:0][ADDR_WIDTH:0]    len_mem;

  logic                              w_state;
  logic [SLOT_BITS-1:0]              wr_slot;
  logic [ADDR_WIDTH-1:0]             wr_idx;
  logic [1:0]                        r_state;
  logic [SLOT_BITS-1:0]              rd_slot;
  logic [ADDR_WIDTH-1:0]             rd_idx;

  logic                              accept;
  logic                              wr_beat;
  logic                              commit;
  logic                              overflow_hit;
  logic                              rd_adv;
  logic                              rd_done;
  logic                              rd_next;
  logic [ADDR_WIDTH-1:0]             rd_idx_nxt;
  logic [SLOT_BITS+ADDR_WIDTH-1:0]   rd_addr;

  assign s_ready      = (pkt_count != FULL_CNT);
  assign accept       = s_valid && s_ready;
  assign wr_beat      = accept && !s_abort && (w_state == W_ACCEPT);
  assign commit       = wr_beat && s_last;
  assign overflow_hit = wr_beat && !s_last && (wr_idx == LAST_IDX);

  assign rd_adv     = (r_state == R_SEND) && m_ready;
  assign rd_done    = rd_adv && m_last;
  assign rd_next    = rd_adv && !m_last;
  assign rd_idx_nxt = rd_idx + IDX_ONE;
  // Read-ahead: while a word is handed over, the next one is fetched into m_data.
  assign rd_addr    = (r_state == R_FETCH) ? {rd_slot, {ADDR_WIDTH{1'b0}}} : {rd_slot, rd_idx_nxt};

  always_ff @(posedge clk) begin
    if (wr_beat) begin
      mem[{wr_slot, wr_idx}] <= s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state      <= W_ACCEPT;
      wr_slot      <= '0;
      wr_idx       <= '0;
      len_mem      <= '0;
      overflow_err <= 1'b0;
    end else begin
      overflow_err <= overflow_hit;
      if (accept) begin
        if (s_abort) begin
          wr_idx  <= '0;
          w_state <= W_ACCEPT;
        end else if (w_state == W_DROP) begin
          if (s_last) begin
            w_state <= W_ACCEPT;
          end
        end else if (s_last) begin
          len_mem[wr_slot] <= {1'b0, wr_idx} + LEN_ONE;
          wr_slot          <= wr_slot + SLOT_ONE;
          wr_idx           <= '0;
        end else if (wr_idx == LAST_IDX) begin
          w_state <= W_DROP;
          wr_idx  <= '0;
        end else begin
          wr_idx <= wr_idx + IDX_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count <= '0;
    end else if (commit && !rd_done) begin
      pkt_count <= pkt_count + PKT_ONE;
    end else if (rd_done && !commit) begin
      pkt_count <= pkt_count - PKT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data <= '0;
    end else if ((r_state == R_FETCH) || rd_next) begin
      m_data <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      rd_slot <= '0;
      rd_idx  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_len   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (pkt_count != '0) begin
            r_state <= R_FETCH;
          end
        end
        R_FETCH: begin
          r_state <= R_SEND;
          rd_idx  <= '0;
          m_valid <= 1'b1;
          m_len   <= len_mem[rd_slot];
          m_last  <= (len_mem[rd_slot] == LEN_ONE);
        end
        R_SEND: begin
          if (rd_done) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_len   <= '0;
            rd_slot <= rd_slot + SLOT_ONE;
            // A commit landing on the same edge still counts as "another packet".
            r_state <= ((pkt_count > PKT_ONE) || commit) ? R_FETCH : R_IDLE;
          end else if (rd_next) begin
            rd_idx <= rd_idx_nxt;
            m_last <= (({1'b0, rd_idx_nxt} + LEN_ONE) == m_len);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hycontrol_packet_buffer.sv
// Directed bench for hycontrol_packet_buffer: scoreboarded read stream plus hand-computed spot checks.
module tb_hycontrol_packet_buffer;

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_abort;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic [5:0] m_len;
  logic       m_ready;
  logic [1:0] pkt_count;
  logic       overflow_err;

  hycontrol_packet_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .SLOT_BITS(1)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_abort(s_abort), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_len(m_len), .m_ready(m_ready),
    .pkt_count(pkt_count), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ovf_cnt = 0;
  int vld_cnt = 0;

  logic [7:0] ex_dat[$];
  logic       ex_last[$];
  logic [5:0] ex_len[$];

  logic       hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;
  logic       hold_l = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_word(input logic [7:0] d, input logic l, input logic [5:0] len);
    ex_dat.push_back(d);
    ex_last.push_back(l);
    ex_len.push_back(len);
  endtask

  // Scoreboard and stall-stability checks, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_vld", m_valid, 1'b1);
        check("hold_dat", m_data, hold_d);
        check("hold_last", m_last, hold_l);
      end
      if (m_valid && m_ready) begin
        if (ex_dat.size() == 0) begin
          check("rx_extra", m_valid, 1'b0);
        end else begin
          check("rx_dat", m_data, ex_dat.pop_front());
          check("rx_last", m_last, ex_last.pop_front());
          check("rx_len", m_len, ex_len.pop_front());
        end
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      hold_l = m_last;
      if (overflow_err) ovf_cnt++;
      if (m_valid) vld_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic put(input logic [7:0] d, input logic l, input logic a);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    s_abort = a;
    while (!s_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("put_timeout", s_ready, 1'b1);
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_abort = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) expect_word(base + 8'(i), (i == n - 1), 6'(n));
    for (int i = 0; i < n; i++) put(base + 8'(i), (i == n - 1), 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while ((ex_dat.size() != 0 || m_valid) && n < 400) begin
      step();
      n++;
    end
    check("drain_left", ex_dat.size(), 0);
    check("drain_cnt", pkt_count, 2'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_s_ready"}, s_ready, 1'b1);
    check({tag, "_m_valid"}, m_valid, 1'b0);
    check({tag, "_m_data"}, m_data, 8'h00);
    check({tag, "_m_last"}, m_last, 1'b0);
    check({tag, "_m_len"}, m_len, 6'd0);
    check({tag, "_pkt_count"}, pkt_count, 2'd0);
    check({tag, "_ovf"}, overflow_err, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat;
    logic       ov33;
    int         base_cnt;

    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; s_abort = 1'b0; m_ready = 1'b0;
    step();
    step();
    check_reset("rst");
    rst = 1'b0;
    step();
    check_reset("post_rst");

    // 1: single 4-word packet, first word two cycles after commit
    m_ready = 1'b1;
    send_pkt(8'h11, 4);
    check("t1_cnt", pkt_count, 2'd1);
    check("t1_vld_e0", m_valid, 1'b0);
    step();
    check("t1_vld_e1", m_valid, 1'b0);
    check("t1_len_e1", m_len, 6'd0);
    step();
    check("t1_vld_e2", m_valid, 1'b1);
    check("t1_dat_e2", m_data, 8'h11);
    check("t1_len_e2", m_len, 6'd4);
    check("t1_last_e2", m_last, 1'b0);
    drain();

    // 2: fill both slots with reads stalled, then release
    m_ready = 1'b0;
    send_pkt(8'h21, 3);
    send_pkt(8'h31, 3);
    step();
    check("t2_cnt", pkt_count, 2'd2);
    check("t2_s_ready", s_ready, 1'b0);
    check("t2_vld", m_valid, 1'b1);
    check("t2_dat", m_data, 8'h21);
    s_valid = 1'b1; s_data = 8'h99; s_last = 1'b1;
    repeat (3) step();
    check("t2_stall_ready", s_ready, 1'b0);
    check("t2_stall_cnt", pkt_count, 2'd2);
    s_valid = 1'b0; s_last = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pat[7 - i] = m_valid;
      step();
    end
    check("t2_bubble", pat, 8'b1110_1110);
    drain();

    // 3: 35-word packet overflows on the 33rd beat and is dropped
    base_cnt = ovf_cnt;
    ov33 = 1'b0;
    for (int i = 0; i < 35; i++) begin
      if (i == 32) ov33 = overflow_err;
      put(8'(i), (i == 34), 1'b0);
    end
    step();
    step();
    check("t3_ovf_at33", ov33, 1'b1);
    check("t3_ovf_pulses", ovf_cnt - base_cnt, 1);
    check("t3_no_commit", pkt_count, 2'd0);
    check("t3_no_vld", m_valid, 1'b0);
    send_pkt(8'hA1, 2);
    drain();

    // 4: aborted packet, then abort together with last, then a 1-word packet
    put(8'h41, 1'b0, 1'b0);
    put(8'h42, 1'b0, 1'b0);
    put(8'h43, 1'b0, 1'b1);
    repeat (3) step();
    check("t4_abort_cnt", pkt_count, 2'd0);
    expect_word(8'hAA, 1'b0, 6'd2);
    expect_word(8'hBB, 1'b1, 6'd2);
    put(8'hAA, 1'b0, 1'b0);
    put(8'hBB, 1'b1, 1'b0);
    drain();
    put(8'h51, 1'b0, 1'b0);
    put(8'h52, 1'b1, 1'b1);
    repeat (4) step();
    check("t4_abort_last_cnt", pkt_count, 2'd0);
    check("t4_abort_last_vld", m_valid, 1'b0);
    send_pkt(8'hCC, 1);
    drain();

    // 5: 32-word packet under random backpressure
    fork
      send_pkt(8'h80, 32);
      begin
        repeat (150) begin
          step();
          m_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_ready = 1'b1;
    drain();

    // 6: reset in the middle of reading a packet
    m_ready = 1'b0;
    expect_word(8'h61, 1'b0, 6'd3);
    put(8'h61, 1'b0, 1'b0);
    put(8'h62, 1'b0, 1'b0);
    put(8'h63, 1'b1, 1'b0);
    repeat (3) step();
    check("t6_vld", m_valid, 1'b1);
    check("t6_dat0", m_data, 8'h61);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("t6_dat1", m_data, 8'h62);
    #2;
    rst = 1'b1;
    #1;
    check_reset("t6_rst");
    step();
    rst = 1'b0;
    m_ready = 1'b1;
    base_cnt = vld_cnt;
    repeat (20) step();
    check("t6_no_emit", vld_cnt - base_cnt, 0);
    check("t6_cnt", pkt_count, 2'd0);
    check("t6_left", ex_dat.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
